// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A 32-bit word and an 8-bit decimal-point mask are captured into shadow
// registers on Load; the scan walks digits 0..7, one slot of ScanDiv cycles
// each, with the first BlankTicks cycles of every slot dark to avoid ghosting.
// All outputs are registered (one cycle behind the scan state).
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading
// zero digits (digit k >= 1 is dark when nibbles 7..k are zero and its
// decimal point is off). Scan timing is identical with or without it.
module seg7_scan_driver #(
    parameter int ScanDiv    = 100000,
    parameter int BlankTicks = 16,
    parameter int NrOfBits   = 32
) (
    input  logic        GlobalClock,
    input  logic        RST,
    input  logic [31:0] Value,
    input  logic        Load,
    input  logic [7:0]  DpMask,
    output logic [7:0]  NA,
    output logic [7:0]  SEG,
    output logic [2:0]  Digit
);

    localparam logic [NrOfBits-1:0] CntLast  = NrOfBits'(ScanDiv - 1);
    localparam logic [NrOfBits-1:0] CntBlank = NrOfBits'(BlankTicks);

    // Scan state
    logic [NrOfBits-1:0] cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;

    // Shadow copy of the display data; the scan reads only these
    logic [31:0]         shv_q, shv_d;
    logic [7:0]          shdp_q, shdp_d;

    // Registered outputs
    logic [7:0]          na_q, na_d;
    logic [7:0]          seg_q, seg_d;
    logic [2:0]          digit_q, digit_d;

    // Per-digit suppression flags (all zero unless leading-zero blanking is built in)
    logic [7:0]          lz_vec;

    // Active-low hex decoder, gfedcba order
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more-significant nibble are
    // zero and it carries no decimal point; the rightmost digit always shows.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lz
            if (gi == 0) begin : g_first
                assign lz_vec[gi] = 1'b0;
            end else begin : g_rest
                assign lz_vec[gi] = (shv_q[31:4*gi] == '0) && !shdp_q[gi];
            end
        end
    endgenerate
`else
    assign lz_vec = '0;
`endif

    // Next-state for prescaler, digit index, shadow registers and outputs
    always_comb begin
        logic [3:0] nib;

        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shv_d   = shv_q;
        shdp_d  = shdp_q;
        na_d    = 8'hFF;
        seg_d   = 8'hFF;
        digit_d = idx_q;
        nib     = shv_q[{idx_q, 2'b00} +: 4];

        if (cnt_q == CntLast) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (Load) begin
            shv_d  = Value;
            shdp_d = DpMask;
        end

        // Outside the dark head of the slot, light the selected digit
        if (!(cnt_q < CntBlank) && !lz_vec[idx_q]) begin
            na_d  = ~(8'b0000_0001 << idx_q);
            seg_d = {~shdp_q[idx_q], hex7(nib)};
        end
    end

    // State and output registers; reset dominates a simultaneous Load
    always_ff @(posedge GlobalClock) begin
        if (RST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shv_q   <= '0;
            shdp_q  <= '0;
            na_q    <= 8'hFF;
            seg_q   <= 8'hFF;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shv_q   <= shv_d;
            shdp_q  <= shdp_d;
            na_q    <= na_d;
            seg_q   <= seg_d;
            digit_q <= digit_d;
        end
    end

    assign NA    = na_q;
    assign SEG   = seg_q;
    assign Digit = digit_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (ScanDiv=4 with BlankTicks=1 and 2)
// share one stimulus. A frame-position model predicts every output cycle;
// directed slot checks pin the model with hand-computed values.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dpm = '0;

    logic [7:0]  na_a, seg_a, na_b, seg_b;
    logic [2:0]  dig_a, dig_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.ScanDiv(4), .BlankTicks(1), .NrOfBits(8)) dut_a (
        .GlobalClock(clk), .RST(rst), .Value(value), .Load(load), .DpMask(dpm),
        .NA(na_a), .SEG(seg_a), .Digit(dig_a)
    );

    seg7_scan_driver #(.ScanDiv(4), .BlankTicks(2), .NrOfBits(8)) dut_b (
        .GlobalClock(clk), .RST(rst), .Value(value), .Load(load), .DpMask(dpm),
        .NA(na_b), .SEG(seg_b), .Digit(dig_b)
    );

    logic [7:0] hex_tab [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] na_of(input int d);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << d);
    endfunction

    // Model: frame position p (0..31) of the cycle being registered
    function automatic void model_out(input int p, input int blank, input logic [31:0] shv,
                                      input logic [7:0] dp, output logic [7:0] na,
                                      output logic [7:0] seg);
        int c;
        int k;
        logic [31:0] upper;
        bit sup;
        c = p % 4;
        k = p / 4;
        upper = shv >> (4 * k);
        sup = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k >= 1 && upper == 32'd0 && dp[k] == 1'b0) sup = 1'b1;
`endif
        if (c < blank || sup) begin
            na  = 8'hFF;
            seg = 8'hFF;
        end else begin
            na  = na_of(k);
            seg = hex_tab[upper[3:0]] & (dp[k] ? 8'h7F : 8'hFF);
        end
    endfunction

    int          pos = 0;
    logic [31:0] m_shv = '0;
    logic [7:0]  m_dp = '0;
    bit          m_valid = 1'b0;
    bit          m_rst = 1'b0;
    logic [7:0]  e_na_a, e_seg_a, e_na_b, e_seg_b;
    logic [2:0]  e_dig;

    // Advance the model on each rising edge using the inputs the DUT samples
    always @(posedge clk) begin
        if (rst) begin
            e_na_a = 8'hFF; e_seg_a = 8'hFF;
            e_na_b = 8'hFF; e_seg_b = 8'hFF;
            e_dig  = 3'd0;
            pos    = 0;
            m_shv  = '0;
            m_dp   = '0;
            m_rst  = 1'b1;
        end else begin
            model_out(pos, 1, m_shv, m_dp, e_na_a, e_seg_a);
            model_out(pos, 2, m_shv, m_dp, e_na_b, e_seg_b);
            e_dig = 3'(pos / 4);
            pos   = (pos + 1) % 32;
            if (load) begin
                m_shv = value;
                m_dp  = dpm;
            end
            m_rst = 1'b0;
        end
        m_valid = 1'b1;
    end

    logic [7:0] prev_a = 8'hFF;
    logic [7:0] prev_b = 8'hFF;
    int         ff_run = 0;

    // Compare every cycle, plus the digit-select safety properties
    always @(negedge clk) begin
        if (m_valid) begin
            chk("na_a", na_a, e_na_a);
            chk("seg_a", seg_a, e_seg_a);
            chk("dig_a", dig_a, e_dig);
            chk("na_b", na_b, e_na_b);
            chk("seg_b", seg_b, e_seg_b);
            chk("dig_b", dig_b, e_dig);
            chk("onehot_a", 32'($countones(~na_a) <= 1), 32'd1);
            chk("onehot_b", 32'($countones(~na_b) <= 1), 32'd1);
            if (prev_a != 8'hFF && na_a != 8'hFF) chk("adjacent_a", na_a, prev_a);
            if (prev_b != 8'hFF && na_b != 8'hFF) chk("adjacent_b", na_b, prev_b);
            if (m_rst) begin
                ff_run = 0;
            end else if (na_b == 8'hFF) begin
                ff_run++;
            end else begin
                if (prev_b == 8'hFF) chk("blank_run_b", ff_run % 4, 2);
                ff_run = 0;
            end
            prev_a = na_a;
            prev_b = na_b;
        end
    end

    task automatic load_word(input logic [31:0] v, input logic [7:0] d);
        value = v;
        dpm   = d;
        load  = 1'b1;
        $display("load value=%08h dp=%02h", v, d);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Wait for a fresh entry into digit d on dut_a, then check its active cycle
    task automatic check_slot(input int d, input logic [7:0] na_e, input logic [7:0] seg_e,
                              input string name);
        int guard;
        guard = 0;
        while (dig_a == 3'(d) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        while (dig_a != 3'(d) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: digit %0d never reached, got digit %0d", name, d, dig_a);
        end else begin
            @(negedge clk);
            chk($sformatf("%s_na%0d", name, d), na_a, na_e);
            chk($sformatf("%s_seg%0d", name, d), seg_a, seg_e);
            $display("slot %s digit=%0d NA=%02h SEG=%02h", name, d, na_a, seg_a);
        end
    endtask

    logic [7:0] scan_seg [8];

    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        scan_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_na", na_a, 8'hFF);
        chk("rst_seg", seg_a, 8'hFF);
        chk("rst_dig", dig_a, 3'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_blank", na_a, 8'hFF);
        @(negedge clk);
        chk("post_rst_na", na_a, 8'hFE);
        chk("post_rst_seg", seg_a, 8'hC0);

        // Full scan and wrap
        load_word(32'h76543210, 8'h00);
        for (int d = 1; d < 8; d++) check_slot(d, na_of(d), scan_seg[d], "scan");
        check_slot(0, 8'hFE, 8'hC0, "wrap");

        // Hex letters and decimal points
        load_word(32'hFEDCBA98, 8'h05);
        check_slot(0, 8'hFE, 8'h00, "dp");
        check_slot(1, 8'hFD, 8'h90, "dp");
        check_slot(2, 8'hFB, 8'h08, "dp");
        check_slot(7, 8'h7F, 8'h8E, "dp");

        // Load and reset on the same edge: reset wins
        rst   = 1'b1;
        load  = 1'b1;
        value = 32'h1;
        dpm   = 8'h00;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        chk("coll_rst_na", na_a, 8'hFF);
        @(negedge clk);
        chk("coll_blank", na_a, 8'hFF);
        @(negedge clk);
        chk("coll_na", na_a, 8'hFE);
        chk("coll_seg", seg_a, 8'hC0);

        // Mid-slot load: visible two edges later, same digit
        value = 32'h88888888;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("mid_old_seg", seg_a, 8'hC0);
        chk("mid_old_dig", dig_a, 3'd0);
        @(negedge clk);
        chk("mid_new_seg", seg_a, 8'h80);
        chk("mid_new_dig", dig_a, 3'd0);

        // Leading-zero handling
        load_word(32'h00000A05, 8'h00);
        check_slot(0, 8'hFE, 8'h92, "lz");
        check_slot(1, 8'hFD, 8'hC0, "lz");
        check_slot(2, 8'hFB, 8'h88, "lz");
        for (int d = 3; d < 8; d++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            check_slot(d, 8'hFF, 8'hFF, "lz");
`else
            check_slot(d, na_of(d), 8'hC0, "lz");
`endif
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
